tm_step_controller: RTL and testbench

TM_STEP_CONTROLLER -- requirements
Module: tm_step_controller

---
 rtl/tm_ctrl_pkg.sv | 19 +
 rtl/tm_tick_div.sv | 35 +++
 rtl/tm_step_controller.sv | 111 +++++++++++
 tb/tb_tm_step_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tm_ctrl_pkg.sv
// Shared definitions for the step controller: state encoding, widths and a
// saturating counter helper.
package tm_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned COUNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/tm_tick_div.sv
// Programmable step-tick divider: period = BASE_DIV << rate_sel, registered
// single-cycle tick on each wrap, counter held at zero while disabled.
module tm_tick_div #(
    parameter int unsigned BASE_DIV = 250000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    output logic       tick
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_DIV);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_m1;

    // Period follows rate_sel live; the >= compare makes a shrink wrap at once.
    always_comb period_m1 = (BASE << rate_sel) - CNT_W'(1);

    always_ff @(posedge clk_in) begin
        if (reset || !enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= period_m1) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/tm_step_controller.sv
// Run/pause/single-step controller for the machine core: command FSM,
// step_req/step_ack handshake, acknowledged-step counter and overrun flag.
module tm_step_controller
    import tm_ctrl_pkg::*;
#(
    parameter int unsigned BASE_DIV = 250000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [1:0]         rate_sel,
    input  logic               run_btn,
    input  logic               pause_btn,
    input  logic               step_btn,
    input  logic               halt_in,
    input  logic               step_ack,
    output logic               step_req,
    output logic [STATE_W-1:0] state,
    output logic [COUNT_W-1:0] step_count,
    output logic               overrun,
    output logic               tick_out
);

    ctrl_state_t state_q;
    logic        pend;
    logic        ack_ok_c;
    logic        tick_run_c;
    logic        step_go_c;
    logic        new_req_c;

    tm_tick_div #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_div (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (state_q == ST_RUN),
        .rate_sel (rate_sel),
        .tick     (tick_out)
    );

    assign state = state_q;

    always_comb begin
        ack_ok_c   = step_ack && step_req;
        tick_run_c = tick_out && (state_q == ST_RUN);
        step_go_c  = (state_q == ST_IDLE) && !halt_in && !pause_btn && step_btn;
        new_req_c  = tick_run_c || step_go_c;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_req   <= 1'b0;
            step_count <= '0;
            overrun    <= 1'b0;
            pend       <= 1'b0;
        end else begin
            if (ack_ok_c) begin
                step_count <= sat_inc(step_count);
            end

            // A request colliding with an ack is parked for one cycle so the
            // core always sees step_req low between two requests.
            if (ack_ok_c) begin
                step_req <= 1'b0;
                pend     <= new_req_c;
            end else if (pend) begin
                step_req <= 1'b1;
                pend     <= 1'b0;
            end else if (new_req_c) begin
                if (tick_run_c && step_req) begin
                    overrun <= 1'b1;
                end
                step_req <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (halt_in) begin
                        state_q <= ST_HALTED;
                    end else if (pause_btn) begin
                        state_q <= ST_IDLE;
                    end else if (step_btn) begin
                        state_q <= ST_STEP;
                    end else if (run_btn) begin
                        state_q <= ST_RUN;
                        overrun <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_in) begin
                        state_q <= ST_HALTED;
                    end else if (pause_btn) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    if (halt_in) begin
                        state_q <= ST_HALTED;
                    end else if (ack_ok_c) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_step_controller.sv
// Directed self-checking bench for tm_step_controller with BASE_DIV=4.
module tb_tm_step_controller;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rate_sel = 2'd0;
    logic        run_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_in = 1'b0;
    logic        step_ack = 1'b0;
    logic        step_req;
    logic [1:0]  state;
    logic [15:0] step_count;
    logic        overrun;
    logic        tick_out;

    int unsigned total = 0;
    int unsigned bad = 0;

    tm_step_controller #(
        .BASE_DIV (4),
        .CNT_W    (8)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .rate_sel   (rate_sel),
        .run_btn    (run_btn),
        .pause_btn  (pause_btn),
        .step_btn   (step_btn),
        .halt_in    (halt_in),
        .step_ack   (step_ack),
        .step_req   (step_req),
        .state      (state),
        .step_count (step_count),
        .overrun    (overrun),
        .tick_out   (tick_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_req", 32'(step_req), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_tick", 32'(tick_out), 32'd0);
        reset = 1'b0;

        // Free run at rate 0, ack two cycles after each request
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("s1_state_run", 32'(state), 32'd1);
        for (int e = 1; e <= 3; e++) begin
            cyc();
            chk("s1_pre_tick", 32'(tick_out), 32'd0);
        end
        cyc();
        chk("s1_first_tick", 32'(tick_out), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("s1_req_rise", 32'(step_req), 32'd1);
            chk("s1_tick_low", 32'(tick_out), 32'd0);
            cyc();
            chk("s1_req_hold", 32'(step_req), 32'd1);
            step_ack = 1'b1;
            cyc();
            step_ack = 1'b0;
            chk("s1_req_drop", 32'(step_req), 32'd0);
            chk("s1_count", 32'(step_count), 32'(k + 1));
            cyc();
            chk("s1_tick", 32'(tick_out), 32'd1);
        end
        chk("s1_overrun", 32'(overrun), 32'd0);
        chk("s1_count3", 32'(step_count), 32'd3);

        // Rate 2 (period 16) with the ack withheld: overrun on second tick
        do_reset();
        rate_sel = 2'd2;
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            cyc();
            chk("s2_no_tick", 32'(tick_out), 32'd0);
        end
        cyc();
        chk("s2_tick16", 32'(tick_out), 32'd1);
        cyc();
        chk("s2_req", 32'(step_req), 32'd1);
        chk("s2_ovr_early", 32'(overrun), 32'd0);
        for (int n = 18; n <= 37; n++) begin
            cyc();
            chk("s2_req_held", 32'(step_req), 32'd1);
            chk("s2_tick32", 32'(tick_out), 32'(n == 32));
            chk("s2_overrun", 32'(overrun), 32'(n >= 33));
        end
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("s2_late_ack_req", 32'(step_req), 32'd0);
        chk("s2_late_ack_cnt", 32'(step_count), 32'd1);
        chk("s2_ovr_sticky", 32'(overrun), 32'd1);

        // Single step from IDLE, second step_btn ignored
        rate_sel = 2'd0;
        do_reset();
        step_btn = 1'b1;
        cyc();
        chk("s3_state_step", 32'(state), 32'd2);
        chk("s3_req", 32'(step_req), 32'd1);
        cyc();
        step_btn = 1'b0;
        chk("s3_step_ign_state", 32'(state), 32'd2);
        chk("s3_step_ign_req", 32'(step_req), 32'd1);
        cyc();
        chk("s3_wait", 32'(step_req), 32'd1);
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("s3_idle", 32'(state), 32'd0);
        chk("s3_req_low", 32'(step_req), 32'd0);
        chk("s3_count", 32'(step_count), 32'd1);
        cyc();
        chk("s3_one_req", 32'(step_req), 32'd0);
        chk("s3_count_hold", 32'(step_count), 32'd1);

        // Halt wins over pause, outstanding request completes, run ignored
        do_reset();
        step_btn = 1'b1;
        cyc();
        step_btn = 1'b0;
        halt_in = 1'b1;
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        chk("s4_halted", 32'(state), 32'd3);
        chk("s4_req_kept", 32'(step_req), 32'd1);
        cyc();
        chk("s4_req_kept2", 32'(step_req), 32'd1);
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("s4_req_drop", 32'(step_req), 32'd0);
        chk("s4_count", 32'(step_count), 32'd1);
        halt_in = 1'b0;
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("s4_run_ign", 32'(state), 32'd3);
        cyc();
        chk("s4_still_halted", 32'(state), 32'd3);
        chk("s4_no_req", 32'(step_req), 32'd0);

        // Rate 3 -> 0 at count 10 wraps next cycle, then reset mid-request
        do_reset();
        rate_sel = 2'd3;
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            chk("s5_no_tick", 32'(tick_out), 32'd0);
        end
        rate_sel = 2'd0;
        cyc();
        chk("s5_wrap_now", 32'(tick_out), 32'd1);
        cyc();
        chk("s5_req", 32'(step_req), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("s5_rst_state", 32'(state), 32'd0);
        chk("s5_rst_req", 32'(step_req), 32'd0);
        chk("s5_rst_count", 32'(step_count), 32'd0);
        chk("s5_rst_ovr", 32'(overrun), 32'd0);
        chk("s5_rst_tick", 32'(tick_out), 32'd0);
        step_ack = 1'b1;
        cyc();
        step_ack = 1'b0;
        chk("s5_stray_cnt", 32'(step_count), 32'd0);
        chk("s5_stray_state", 32'(state), 32'd0);
        chk("s5_stray_req", 32'(step_req), 32'd0);

        // Saturation: 65537 acks via step/ack alternation
        do_reset();
        step_btn = 1'b1;
        step_ack = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            cyc();
            cyc();
        end
        chk("s6_fffe", 32'(step_count), 32'hFFFE);
        cyc();
        cyc();
        chk("s6_ffff", 32'(step_count), 32'hFFFF);
        for (int i = 0; i < 2; i++) begin
            cyc();
            cyc();
        end
        step_btn = 1'b0;
        step_ack = 1'b0;
        chk("s6_sat_hold", 32'(step_count), 32'hFFFF);
        chk("s6_idle", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
